mdu_unit: RTL



---
 rtl/mdu_unit_pkg.sv | 29 ++
 rtl/mdu_unit_md_compute.sv | 54 +++++
 rtl/mdu_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/mdu_unit_pkg.sv
// Shared op-code constants, FSM state type and op-class helpers for the multiply/divide unit.
// Nothing here holds state.
package mdu_unit_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Any md-class op in D must wait behind the unit, including moves.
    function automatic logic is_mult_class(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_MTLO);
    endfunction

    function automatic logic is_launch_op(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_unit_md_compute.sv
// Combinational 64-bit multiply / divide datapath; result is {HI, LO}.
// Zero latency; the caller decides when to latch the result.
module md_compute
    import mdu_unit_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] result_o,
    output logic        div_by_zero_o
);

    logic [63:0] smul;
    logic [63:0] umul;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Low 64 bits of the sign-extended product equal the exact signed product.
    assign smul = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
    assign umul = {32'd0, a_i} * {32'd0, b_i};

    // Signed divide via magnitudes; 0x80000000 / -1 wraps naturally to 0x80000000 rem 0.
    assign a_neg  = (op_i == MD_DIV) && a_i[31];
    assign b_neg  = (op_i == MD_DIV) && b_i[31];
    assign a_mag  = a_neg ? (32'd0 - a_i) : a_i;
    assign b_mag  = b_neg ? (32'd0 - b_i) : b_i;
    assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem    = a_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        result_o      = 64'd0;
        div_by_zero_o = 1'b0;
        case (op_i)
            MD_MULT:  result_o = smul;
            MD_MULTU: result_o = umul;
            MD_DIV, MD_DIVU: begin
                result_o      = {rem, quot};
                div_by_zero_o = (b_i == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit holding HI/LO; mult/div commit after MULT_CYCLES/DIV_CYCLES busy cycles.
// Starts while busy are dropped; E_start_busy lets the hazard unit stall md ops in D.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic [3:0]  E_md_op,
    input  logic        E_start,
    output logic        E_busy,
    output logic        E_start_busy,
    output logic [31:0] E_md_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_dz_q, pend_dz_d;

    logic [63:0]      result;
    logic             div_by_zero;

    md_compute u_compute (
        .op_i          (E_md_op),
        .a_i           (E_A),
        .b_i           (E_B),
        .result_o      (result),
        .div_by_zero_o (div_by_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_dz_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_dz_q <= pend_dz_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_dz_d = pend_dz_q;
        case (state_q)
            ST_IDLE: begin
                if (E_start) begin
                    if (is_launch_op(E_md_op)) begin
                        pend_hi_d = result[63:32];
                        pend_lo_d = result[31:0];
                        pend_dz_d = div_by_zero;
                        cnt_d     = ((E_md_op == MD_MULT) || (E_md_op == MD_MULTU))
                                    ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        state_d   = ST_RUN;
                    end else if (E_md_op == MD_MTHI) begin
                        hi_d = E_A;
                    end else if (E_md_op == MD_MTLO) begin
                        lo_d = E_A;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    // Divide by zero leaves HI/LO untouched but still costs the full busy time.
                    if (!pend_dz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign E_busy       = (state_q == ST_RUN);
    assign E_start_busy = E_busy || (E_start && is_mult_class(E_md_op));

    always_comb begin
        E_md_out = 32'd0;
        if (E_start && (E_md_op == MD_MFHI)) begin
            E_md_out = hi_q;
        end else if (E_start && (E_md_op == MD_MFLO)) begin
            E_md_out = lo_q;
        end
    end

endmodule
